// File: rtl/hash_block_assembler_pkg.sv
// Shared constants and types for the hash block assembler: block geometry,
// the pad marker and the FSM state encoding.
package hash_block_assembler_pkg;

    localparam int BLOCK_W = 512;
    localparam int BYTE_W  = 8;
    localparam int NB      = BLOCK_W / BYTE_W;
    localparam int CNT_W   = 7;

    localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h80;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } state_e;

endpackage

// File: rtl/hash_block_assembler_if.sv
// Byte-stream input and block-stream output of the assembler. The master
// modport is the surrounding system; slave is the assembler itself.
interface hash_block_assembler_if;
    import hash_block_assembler_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BYTE_W-1:0]    in_data;
    logic                 in_last;
    logic                 blk_valid;
    logic                 blk_ready;
    logic [BLOCK_W-1:0]   blk_data;
    logic [CNT_W-1:0]     blk_bytes;
    logic                 blk_last;

    modport master (
        output in_valid, in_data, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_bytes, blk_last
    );

    modport slave (
        input  in_valid, in_data, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_bytes, blk_last
    );

endinterface

// File: rtl/hash_block_assembler.sv
// Packs a byte stream MSB-first into 512-bit blocks, appends the 0x80 marker
// after the final byte, and emits an extra pad-only block when the message fills a block exactly.
module hash_block_assembler
    import hash_block_assembler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    hash_block_assembler_if.slave bus
);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NB-1:0][BYTE_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]             bytes_q, bytes_d;
    logic                         last_q, last_d;
    logic                         pad_pending_q, pad_pending_d;

    logic byte_acc, blk_acc;
    logic wr_en, pad_en, clr, load_pad;

    assign byte_acc = bus.in_valid  && (state_q == ST_FILL);
    assign blk_acc  = bus.blk_ready && (state_q == ST_OUT);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bytes_d       = bytes_q;
        last_d        = last_q;
        pad_pending_d = pad_pending_q;
        wr_en         = 1'b0;
        pad_en        = 1'b0;
        clr           = 1'b0;
        load_pad      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (byte_acc) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 7'd1;
                    if (bus.in_last) begin
                        state_d = ST_OUT;
                        if (cnt_q != CNT_W'(NB - 1)) begin
                            pad_en  = 1'b1;
                            bytes_d = cnt_q + 7'd1;
                            last_d  = 1'b1;
                        end else begin
                            bytes_d       = CNT_W'(NB);
                            last_d        = 1'b0;
                            pad_pending_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(NB - 1)) begin
                        state_d = ST_OUT;
                        bytes_d = CNT_W'(NB);
                        last_d  = 1'b0;
                    end
                end
            end
            ST_OUT: begin
                if (blk_acc) begin
                    clr = 1'b1;
                    if (pad_pending_q) begin
                        // Message ended exactly on a block boundary: marker-only block follows.
                        load_pad      = 1'b1;
                        bytes_d       = '0;
                        last_d        = 1'b1;
                        pad_pending_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        bytes_d = '0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Byte-lane write decoder: slot k lives at buf_q[NB-1-k] so slot 0 is the MSB byte.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        localparam logic [CNT_W-1:0] SLOT = CNT_W'(k);
        assign buf_d[NB-1-k] = clr                              ? ((k == 0 && load_pad) ? PAD_BYTE : '0) :
                               (wr_en  && cnt_q == SLOT)          ? bus.in_data :
                               (pad_en && cnt_q + 7'd1 == SLOT)   ? PAD_BYTE :
                                                                    buf_q[NB-1-k];
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the block buffer is reset too, because blk_data must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            buf_q         <= '0;
            bytes_q       <= '0;
            last_q        <= 1'b0;
            pad_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            bytes_q       <= bytes_d;
            last_q        <= last_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.blk_valid = (state_q == ST_OUT);
    assign bus.blk_data  = buf_q;
    assign bus.blk_bytes = bytes_q;
    assign bus.blk_last  = last_q;

endmodule

// File: tb/tb_hash_block_assembler.sv
// Directed bench for hash_block_assembler: short, exact-fit, multi-block,
// back-pressure, mid-message reset and randomly throttled handshakes.
module tb_hash_block_assembler;
    import hash_block_assembler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hash_block_assembler_if bif ();

    hash_block_assembler dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    typedef struct {
        logic [BLOCK_W-1:0] data;
        logic [CNT_W-1:0]   bytes;
        logic               last;
    } blk_t;

    blk_t got_q[$];
    int   checks = 0;
    int   errors = 0;
    logic stop_rand;

    logic [BLOCK_W-1:0] exp_seq;    // bytes 0x00..0x3F in slot order
    logic [BLOCK_W-1:0] exp_t1;

    // Record every accepted block just after the negedge when inputs have settled.
    always begin
        @(negedge clk);
        #1;
        if (bif.blk_valid && bif.blk_ready)
            got_q.push_back('{bif.blk_data, bif.blk_bytes, bif.blk_last});
    end

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        bif.in_last  = last;
        while (!bif.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n == 300) check("in_ready_wait", bif.in_ready, 1);
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic expect_block(input string tag, input logic [BLOCK_W-1:0] data,
                                input logic [CNT_W-1:0] bytes, input logic last);
        int   n = 0;
        blk_t b;
        while (got_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_present"}, got_q.size() != 0, 1);
        if (got_q.size() != 0) begin
            b = got_q.pop_front();
            check({tag, "_data"},  b.data,  data);
            check({tag, "_bytes"}, b.bytes, bytes);
            check({tag, "_last"},  b.last,  last);
        end
    endtask

    initial begin
        exp_t1 = {32'h6162_6380, 480'h0};
        for (int i = 0; i < NB; i++) exp_seq[BLOCK_W-1-8*i -: 8] = 8'(i);

        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.in_last   = 1'b0;
        bif.blk_ready = 1'b0;
        stop_rand     = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_in_ready",  bif.in_ready,  1);
        check("rst_blk_valid", bif.blk_valid, 0);
        check("rst_blk_data",  bif.blk_data,  0);
        check("rst_blk_bytes", bif.blk_bytes, 0);
        check("rst_blk_last",  bif.blk_last,  0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: "abc"
        bif.blk_ready = 1'b1;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        check("t1_latency", bif.blk_valid, 1);
        expect_block("t1", exp_t1, 7'd3, 1'b1);

        // Test 2: exactly 64 bytes -> full block plus marker-only block
        for (int i = 0; i < NB; i++) send_byte(8'(i), i == NB - 1);
        expect_block("t2a", exp_seq, 7'd64, 1'b0);
        expect_block("t2b", {8'h80, 504'h0}, 7'd0, 1'b1);

        // Test 3: 70 bytes of 0xFF
        for (int i = 0; i < 70; i++) send_byte(8'hFF, i == 69);
        expect_block("t3a", {BLOCK_W{1'b1}}, 7'd64, 1'b0);
        expect_block("t3b", {48'hFFFF_FFFF_FFFF, 8'h80, 456'h0}, 7'd6, 1'b1);

        // Test 4: back-pressure with a byte waiting on the input
        bif.blk_ready = 1'b0;
        for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b0);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'hAA;
        bif.in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_data", bif.blk_data, exp_seq);
            check("t4_hold_status", {bif.in_ready, bif.blk_valid, bif.blk_bytes, bif.blk_last},
                  {1'b0, 1'b1, 7'd64, 1'b0});
            @(negedge clk);
        end
        check("t4_no_accept", got_q.size(), 0);
        bif.blk_ready = 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        expect_block("t4a", exp_seq, 7'd64, 1'b0);
        expect_block("t4b", {8'hAA, 8'hBB, 8'h80, 488'h0}, 7'd2, 1'b1);

        // Test 5: reset in the middle of a message
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_blk_valid", bif.blk_valid, 0);
        check("t5_in_ready",  bif.in_ready,  1);
        check("t5_blk_data",  bif.blk_data,  0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_discarded", got_q.size(), 0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        expect_block("t5", exp_t1, 7'd3, 1'b1);

        // Test 6: "abc" with idle gaps and a randomly stalling consumer
        fork
            while (!stop_rand) begin
                @(negedge clk);
                bif.blk_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            send_byte(8'h61 + 8'(i), i == 2);
        end
        expect_block("t6", exp_t1, 7'd3, 1'b1);
        stop_rand = 1'b1;
        repeat (2) @(negedge clk);
        bif.blk_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_no_extra", got_q.size(), 0);
        check("t6_idle", {bif.in_ready, bif.blk_valid}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
